// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer: mode encodings, scan
// direction, the LED count and the 16-entry gamma table used by the BREATHE
// pattern when LED_PATTERN_SEQ_GAMMA_EN is defined.
// No ports (package).
// -----------------------------------------------------------------------------
package led_seq_pkg;

  // Number of LEDs on the board: bit 4 = D1 ... bit 0 = D5.
  localparam int NUM_LEDS = 5;

  // Encoding of the two-bit mode input.
  typedef enum logic [1:0] {
    MODE_BINARY  = 2'b00,
    MODE_SCAN    = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  // Sweep direction shared by the SCAN position and the BREATHE level.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Perceptual brightness curve for a 4-bit level. Low levels are compressed
  // so the ramp looks linear to the eye.
  localparam int GAMMA_ENTRIES = 16;
  localparam logic [3:0] GAMMA_LUT [GAMMA_ENTRIES] = '{
    4'd0, 4'd0, 4'd0,  4'd1,  4'd1,  4'd2,  4'd2,  4'd3,
    4'd4, 4'd5, 4'd6,  4'd8,  4'd9,  4'd11, 4'd13, 4'd15
  };

  function automatic logic [3:0] gamma4(input logic [3:0] level);
    return GAMMA_LUT[level];
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// -----------------------------------------------------------------------------
// led_prescaler
// Free-running DIV_W-bit prescaler that produces one pattern step every
// 2^DIV_W enabled cycles.
//
// Ports
//   clk     in   single clock
//   rst     in   synchronous, active-high reset
//   enable  in   count when high; hold when low
//   clear   in   force the count to zero and swallow any coincident wrap
//   step    out  registered one-cycle pulse, high the cycle after the count
//                was all-ones with enable high
//   wrap    out  combinational "step happens at this edge" strobe, so the
//                parent can update its pattern state on the same edge that
//                step is registered
// -----------------------------------------------------------------------------
module led_prescaler #(
  parameter int DIV_W = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic step,
  output logic wrap
);

  logic [DIV_W-1:0] count;

  // A clear outranks a coincident wrap: the step is dropped entirely.
  always_comb begin
    wrap = enable && (count == {DIV_W{1'b1}}) && !clear;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      step  <= 1'b0;
    end else begin
      step <= wrap;
      if (clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// -----------------------------------------------------------------------------
// led_pattern_seq
// Five-LED pattern sequencer with four modes:
//   BINARY  - 5-bit counter advanced once per step, shown directly on the LEDs
//   SCAN    - a single lit LED bouncing D5 -> D1 -> D5 without repeating the
//             end positions
//   BREATHE - all LEDs PWM-dimmed together; brightness ramps up and down by
//             one level per step
//   OFF     - LEDs dark, pattern state frozen
// A change on the mode input restarts the newly selected pattern from its
// initial state on the following edge.
//
// Parameters
//   DIV_W   prescaler width; one step every 2^DIV_W enabled cycles
//   PWM_W   PWM counter / brightness level width
//
// Ports
//   clk     in   single clock
//   rst     in   synchronous, active-high reset
//   enable  in   advance prescaler and PWM counter when high
//   mode    in   00 BINARY, 01 SCAN, 10 BREATHE, 11 OFF
//   led     out  registered LED drive, bit 4 = D1 ... bit 0 = D5
//   step    out  one-cycle pulse on each pattern step
//
// Build option
//   LED_PATTERN_SEQ_GAMMA_EN  when defined, BREATHE maps its level through
//                             the package gamma table (requires PWM_W == 4);
//                             otherwise the level drives the PWM compare
//                             directly.
// -----------------------------------------------------------------------------
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int DIV_W = 21,
  parameter int PWM_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                step
);

  localparam logic [PWM_W-1:0] LEVEL_MAX = {PWM_W{1'b1}};
  localparam logic [2:0]       POS_LAST  = 3'(NUM_LEDS - 1);

`ifdef LED_PATTERN_SEQ_GAMMA_EN
  // The gamma table only covers 4-bit levels.
  if (PWM_W != 4) begin : g_gamma_width_check
    $fatal(1, "led_pattern_seq: LED_PATTERN_SEQ_GAMMA_EN requires PWM_W == 4");
  end
`endif

  function automatic logic [PWM_W-1:0] gamma(input logic [PWM_W-1:0] lvl);
`ifdef LED_PATTERN_SEQ_GAMMA_EN
    return PWM_W'(gamma4(lvl[3:0]));
`else
    return lvl;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_e                mode_in;
  mode_e                mode_q;
  logic                 mode_change;
  logic                 wrap;

  logic [PWM_W-1:0]     pwm_cnt,  pwm_cnt_n;
  logic [NUM_LEDS-1:0]  pattern,  pattern_n;
  logic [2:0]           pos,      pos_n;
  dir_e                 dir,      dir_n;
  logic [PWM_W-1:0]     level,    level_n;
  logic [NUM_LEDS-1:0]  led_n;

  assign mode_in     = mode_e'(mode);
  assign mode_change = (mode_in != mode_q);

  // ---------------------------------------------------------------------------
  // Prescaler / step generator. A mode change clears it and suppresses any
  // step that would coincide with the change.
  // ---------------------------------------------------------------------------
  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (mode_change),
    .step   (step),
    .wrap   (wrap)
  );

  // ---------------------------------------------------------------------------
  // Next-state and LED logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pwm_cnt_n = pwm_cnt;
    pattern_n = pattern;
    pos_n     = pos;
    dir_n     = dir;
    level_n   = level;
    led_n     = led;

    if (enable) begin
      pwm_cnt_n = pwm_cnt + PWM_W'(1);
    end

    if (mode_change) begin
      // Restart the newly selected pattern; LEDs go dark until it steps.
      pattern_n = '0;
      pos_n     = '0;
      dir_n     = DIR_UP;
      level_n   = '0;
      led_n     = '0;
    end else if (enable) begin
      unique case (mode_in)
        MODE_BINARY: begin
          if (wrap) begin
            pattern_n = pattern + NUM_LEDS'(1);
            led_n     = pattern_n;
          end
        end

        MODE_SCAN: begin
          if (wrap) begin
            // Each step lights the current position and then moves on, so the
            // first step after a restart lights D5.
            led_n = NUM_LEDS'(1) << pos;
            if (dir == DIR_UP) begin
              if (pos == POS_LAST) begin
                pos_n = POS_LAST - 3'd1;
                dir_n = DIR_DOWN;
              end else begin
                pos_n = pos + 3'd1;
              end
            end else begin
              if (pos == 3'd0) begin
                pos_n = 3'd1;
                dir_n = DIR_UP;
              end else begin
                pos_n = pos - 3'd1;
              end
            end
          end
        end

        MODE_BREATHE: begin
          if (wrap) begin
            if (dir == DIR_UP) begin
              if (level == LEVEL_MAX) begin
                level_n = LEVEL_MAX - PWM_W'(1);
                dir_n   = DIR_DOWN;
              end else begin
                level_n = level + PWM_W'(1);
              end
            end else begin
              if (level == '0) begin
                level_n = PWM_W'(1);
                dir_n   = DIR_UP;
              end else begin
                level_n = level - PWM_W'(1);
              end
            end
          end
          // Compare against the post-edge counter and level so the LEDs
          // always agree with the state registered alongside them.
          led_n = {NUM_LEDS{pwm_cnt_n < gamma(level_n)}};
        end

        MODE_OFF: begin
          led_n = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_BINARY;
      pwm_cnt <= '0;
      pattern <= '0;
      pos     <= '0;
      dir     <= DIR_UP;
      level   <= '0;
      led     <= '0;
    end else begin
      mode_q  <= mode_in;
      pwm_cnt <= pwm_cnt_n;
      pattern <= pattern_n;
      pos     <= pos_n;
      dir     <= dir_n;
      level   <= level_n;
      led     <= led_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_seq
// Self-checking bench for led_pattern_seq with DIV_W=2, PWM_W=4. A behavioural
// model tracks each pattern as a phase counter (binary count, position in a
// bounce table, position in a triangle wave) and predicts led/step after
// every clock edge; directed steps add explicit checks of the documented
// LED sequences.
// -----------------------------------------------------------------------------
module tb_led_pattern_seq;

  localparam int DIV_W     = 2;
  localparam int PWM_W     = 4;
  localparam int PRESC_MOD = 1 << DIV_W;
  localparam int PWM_MOD   = 1 << PWM_W;
  localparam int LVL_MAX   = PWM_MOD - 1;
  localparam int BR_PERIOD = 2 * LVL_MAX;
  localparam int BIN_MOD   = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic [4:0] led;
  logic       step;

  always #5 clk = ~clk;

  led_pattern_seq #(
    .DIV_W (DIV_W),
    .PWM_W (PWM_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .led    (led),
    .step   (step)
  );

  int checks = 0;
  int passes = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         m_presc, m_pwm, m_bin, m_scan_ph, m_br_ph;
  logic [1:0] m_mode_q;
  logic [4:0] m_led;
  logic       m_step;
  int         bounce [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  logic [4:0] step_leds [$];
  logic [4:0] scan_exp  [10] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16,
                                 5'd8, 5'd4, 5'd2, 5'd1, 5'd2};

  function automatic int br_level(input int ph);
    return (ph <= LVL_MAX) ? ph : BR_PERIOD - ph;
  endfunction

  task automatic model_edge();
    bit change;
    bit wrap;
    if (rst) begin
      m_presc = 0; m_pwm = 0; m_bin = 0; m_scan_ph = 0; m_br_ph = 0;
      m_mode_q = 2'b00; m_led = '0; m_step = 1'b0;
      return;
    end
    change   = (mode != m_mode_q);
    m_mode_q = mode;
    wrap     = enable && (m_presc == PRESC_MOD - 1) && !change;
    m_step   = wrap;
    if (enable) m_pwm = (m_pwm + 1) % PWM_MOD;
    if (change)      m_presc = 0;
    else if (enable) m_presc = (m_presc + 1) % PRESC_MOD;

    if (change) begin
      m_bin = 0; m_scan_ph = 0; m_br_ph = 0; m_led = '0;
    end else if (enable) begin
      case (mode)
        2'b00: if (wrap) begin
          m_bin = (m_bin + 1) % BIN_MOD;
          m_led = 5'(m_bin);
        end
        2'b01: if (wrap) begin
          m_led     = 5'(1 << bounce[m_scan_ph]);
          m_scan_ph = (m_scan_ph + 1) % 8;
        end
        2'b10: begin
          if (wrap) m_br_ph = (m_br_ph + 1) % BR_PERIOD;
          m_led = (m_pwm < br_level(m_br_ph)) ? 5'h1f : 5'h00;
        end
        default: m_led = '0;
      endcase
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: sample #1 after the edge, advance the model, compare.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    check("led", 32'(led), 32'(m_led));
    check("step", 32'(step), 32'(m_step));
    if (step === 1'b1) step_leds.push_back(led);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00;

    // Reset state.
    repeat (3) cycle();
    check("reset_led", 32'(led), 32'd0);
    check("reset_step", 32'(step), 32'd0);

    // BINARY: one step every 4 cycles, 1..31 then wrap to 0.
    rst = 1'b0; enable = 1'b1;
    step_leds.delete();
    repeat (BIN_MOD * PRESC_MOD) cycle();
    check("bin_nsteps", 32'(step_leds.size()), 32'd32);
    for (int i = 0; i < step_leds.size(); i++)
      check("bin_seq", 32'(step_leds[i]), 32'((i + 1) % BIN_MOD));

    // Mode change to SCAN on the edge where the prescaler wraps.
    repeat (PRESC_MOD - 1) cycle();
    mode = 2'b01;
    cycle();
    check("chg_no_step", 32'(step), 32'd0);
    step_leds.delete();
    repeat (PRESC_MOD) cycle();
    check("scan_first_step", 32'(step), 32'd1);
    check("scan_first_led", 32'(led), 32'h01);

    // SCAN: ten steps bounce without repeating the ends.
    repeat (9 * PRESC_MOD) cycle();
    check("scan_nsteps", 32'(step_leds.size()), 32'd10);
    for (int i = 0; i < step_leds.size() && i < 10; i++)
      check("scan_seq", 32'(step_leds[i]), 32'(scan_exp[i]));

    // enable=0 for 10 cycles: everything frozen, then the sweep resumes.
    enable = 1'b0;
    repeat (10) begin
      cycle();
      check("frz_led", 32'(led), 32'h02);
      check("frz_step", 32'(step), 32'd0);
    end
    enable = 1'b1;
    step_leds.delete();
    repeat (2 * PRESC_MOD) cycle();
    check("resume_nsteps", 32'(step_leds.size()), 32'd2);
    if (step_leds.size() == 2) begin
      check("resume_led0", 32'(step_leds[0]), 32'h04);
      check("resume_led1", 32'(step_leds[1]), 32'h08);
    end

    // Random enable gaps while scanning.
    repeat (60) begin
      enable = 1'($urandom_range(0, 1));
      cycle();
    end
    enable = 1'b1;

    // BREATHE: full up/down ramp; explicit duty checks at the ramp ends.
    mode = 2'b10;
    repeat (2 * BR_PERIOD * PRESC_MOD + 8) begin
      cycle();
      if (m_mode_q == 2'b10 && br_level(m_br_ph) == 0)
        check("br_level0_dark", 32'(led), 32'h00);
      if (m_mode_q == 2'b10 && br_level(m_br_ph) == LVL_MAX)
        check("br_level15_duty", 32'(led), (m_pwm == LVL_MAX) ? 32'h00 : 32'h1f);
    end
    repeat (40) begin
      enable = ($urandom_range(0, 3) != 0);
      cycle();
    end
    enable = 1'b1;

    // Reset mid-BREATHE on the edge where a step would fire.
    for (int k = 0; k < 2 * PRESC_MOD && m_presc != PRESC_MOD - 1; k++) cycle();
    rst = 1'b1;
    cycle();
    check("rst_led", 32'(led), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    mode = 2'b00;
    cycle();
    rst = 1'b0;
    repeat (PRESC_MOD) cycle();
    check("rst_first_step", 32'(step), 32'd1);
    check("rst_first_led", 32'(led), 32'h01);

    // OFF mode keeps the LEDs dark.
    mode = 2'b11;
    repeat (12) cycle();
    check("off_led", 32'(led), 32'd0);

    // Random mode and enable activity.
    repeat (200) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 SHALL have parameter DIV_W, default 21: prescaler width; one pattern step every 2^DIV_W enabled cycles.
REQ-002 SHALL have parameter PWM_W, default 4: PWM counter and brightness level width.
REQ-003 SHALL have port clk  input  1  single clock for all logic, sourced from the global buffer.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port enable  input  1  advance prescaler and PWM counter when high.
REQ-006 SHALL have port mode  input  2  00 BINARY, 01 SCAN, 10 BREATHE, 11 OFF.
REQ-007 SHALL have port led  output  5  registered LED drive, bit 4 = D1 ... bit 0 = D5.
REQ-008 SHALL have port step  output  1  one-cycle pulse on each pattern step.

Function
REQ-009 SHALL increment the DIV_W-bit prescaler by 1 per cycle when enable=1, wrapping all-ones -> 0.
REQ-010 SHALL assert step for exactly the cycle after the prescaler is all-ones with enable=1; otherwise step=0.
REQ-011 SHALL increment the PWM_W-bit PWM counter by 1 per cycle when enable=1, wrapping freely.
REQ-012 SHALL, in BINARY, increment a 5-bit pattern on each step (31 -> 0 wrap) and drive led = pattern.
REQ-013 SHALL, in SCAN, hold a one-hot position 0..4 plus direction; up at 4 -> dir=down, pos=3; down at 0 -> dir=up, pos=1; led = 1 << pos.
REQ-014 SHALL, in BREATHE, ramp level 0..2^PWM_W-1 by 1 per step, reversing at both ends (max -> max-1, 0 -> 1); all led bits = (pwm_cnt < gamma(level)).
REQ-015 SHALL, in OFF, drive led = 0 and hold all pattern state.
REQ-016 SHALL update led and step in the same cycle as the pattern state update (one-cycle latency from the prescaler wrap).
REQ-017 SHALL detect a mode change by comparing against a registered copy; the following cycle it SHALL clear prescaler, pattern, pos, level to 0, set dir=up, and suppress step.
REQ-018 SHALL, with enable=0, hold prescaler, PWM counter, pattern state and led; step=0.
REQ-019 SHALL give a mode change priority over a coincident step.

Reset
REQ-020 SHALL on rst=1 at a clk edge set led=0, step=0, prescaler=0, PWM counter=0, pattern=0, pos=0, dir=up, level=0, registered mode=00.
REQ-021 SHALL allow reset mid-step or mid-ramp; restart from the REQ-020 state with no residual pulse.

Configuration
REQ-022 SHALL, with LED_PATTERN_SEQ_GAMMA_EN defined, map level through a 16-entry gamma table {0,0,0,1,1,2,2,3,4,5,6,8,9,11,13,15} (PWM_W=4 only).
REQ-023 SHALL, without LED_PATTERN_SEQ_GAMMA_EN, use gamma(level)=level (identity, any PWM_W).
REQ-024 SHALL fail elaboration when LED_PATTERN_SEQ_GAMMA_EN is defined and PWM_W != 4.

Structure
REQ-025 SHALL place the mode encodings, LED count (5) and gamma table in shared package led_seq_pkg.
REQ-026 SHALL implement prescaler and step generation in sub-module led_prescaler (DIV_W parameter, clk, rst, enable, clear, step).
REQ-027 SHALL use only flops and LUT logic; no clock gating and no derived clocks.

Verification (bench uses DIV_W=2, PWM_W=4)
REQ-028 SHALL check BINARY, enable=1: step every 4 cycles; led sequence 1,2,...,31,0; wrap 31 -> 0 observed.
REQ-029 SHALL check SCAN: led sequence 10000... as 1,2,4,8,16,8,4,2,1,2 over 10 steps; no repeated endpoint.
REQ-030 SHALL check BREATHE: level 15 -> led high 15 of 16 cycles; level 0 -> led 0; ramp reverses at 15 and at 0.
REQ-031 SHALL check mode change BINARY -> SCAN coincident with the prescaler wrap: no step, led = 00001 after the first SCAN step, 4 cycles later.
REQ-032 SHALL check enable=0 for 10 cycles mid-pattern: led and step frozen; resuming continues the same sequence.
REQ-033 SHALL check rst=1 mid-BREATHE: next cycle led=0, step=0; with mode=00 the first step after release gives led=00001.
